// File: rtl/mux_2to1_sel.sv
// rtl/mux_2to1_sel.sv - 2:1 WIDTH-bit mux with combinational Out and registered Out_q
// Optional MUX_SEL_CNT_EN adds a saturating Sel transition counter on Sel_chg_cnt.
module mux_2to1_sel #(
  parameter int          WIDTH   = 1,
  parameter logic [63:0] RST_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] CH0,
  input  logic [WIDTH-1:0] CH1,
  input  logic             Sel,
  output logic [WIDTH-1:0] Out,
`ifdef MUX_SEL_CNT_EN
  output logic [7:0]       Sel_chg_cnt,
`endif
  output logic [WIDTH-1:0] Out_q
);

  localparam logic [WIDTH-1:0] RST_W = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] out_q_d;
  logic [WIDTH-1:0] out_q_q;

  assign Out = Sel ? CH1 : CH0;

  always_comb begin
    out_q_d = Out;
    if (rst) out_q_d = RST_W;
  end

  always_ff @(posedge clk) begin
    out_q_q <= out_q_d;
  end

  assign Out_q = out_q_q;

`ifdef MUX_SEL_CNT_EN
  logic       sel_d_d;
  logic       sel_d_q;
  logic [7:0] sel_chg_cnt_d;
  logic [7:0] sel_chg_cnt_q;

  // Reset clears the previous-select history to 0, so a Sel=1 on the first edge counts.
  always_comb begin
    sel_d_d       = Sel;
    sel_chg_cnt_d = sel_chg_cnt_q;
    if (rst) begin
      sel_d_d       = 1'b0;
      sel_chg_cnt_d = 8'd0;
    end else if ((Sel != sel_d_q) && (sel_chg_cnt_q != 8'hFF)) begin
      sel_chg_cnt_d = sel_chg_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    sel_d_q       <= sel_d_d;
    sel_chg_cnt_q <= sel_chg_cnt_d;
  end

  assign Sel_chg_cnt = sel_chg_cnt_q;
`endif

endmodule

// File: tb/tb_mux_2to1_sel.sv
// tb/tb_mux_2to1_sel.sv - scoreboard bench for mux_2to1_sel at WIDTH=1 and WIDTH=8
module tb_mux_2to1_sel;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       ch0_1, ch1_1;
  logic [7:0] ch0_8, ch1_8;
  logic       out_1, out_q_1;
  logic [7:0] out_8, out_q_8;
`ifdef MUX_SEL_CNT_EN
  logic [7:0] cnt_1, cnt_8;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       e_out1;
    logic [7:0] e_out8;
    bit         chk_q;
    logic       e_q1;
    logic [7:0] e_q8;
    bit         chk_cnt;
    logic [7:0] e_cnt;
  } item_t;

  item_t sb[$];

  // Model state: a plain transition count since the last reset.
  bit       seen_rst = 0;
  logic     prev_sel_m = 1'b0;
  int       toggles_m = 0;

  mux_2to1_sel #(.WIDTH(1), .RST_VAL(64'd0)) u_w1 (
    .clk(clk), .rst(rst), .CH0(ch0_1), .CH1(ch1_1), .Sel(sel), .Out(out_1),
`ifdef MUX_SEL_CNT_EN
    .Sel_chg_cnt(cnt_1),
`endif
    .Out_q(out_q_1)
  );

  mux_2to1_sel #(.WIDTH(8), .RST_VAL(64'h1C3)) u_w8 (
    .clk(clk), .rst(rst), .CH0(ch0_8), .CH1(ch1_8), .Sel(sel), .Out(out_8),
`ifdef MUX_SEL_CNT_EN
    .Sel_chg_cnt(cnt_8),
`endif
    .Out_q(out_q_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input string name, input logic r, input logic s,
                       input logic c0_1, input logic c1_1,
                       input logic [7:0] c0_8, input logic [7:0] c1_8);
    item_t it;
    @(negedge clk);
    rst = r; sel = s; ch0_1 = c0_1; ch1_1 = c1_1; ch0_8 = c0_8; ch1_8 = c1_8;
    it.name   = name;
    it.e_out1 = s ? c1_1 : c0_1;
    it.e_out8 = s ? c1_8 : c0_8;
    it.e_q1   = r ? 1'b0  : it.e_out1;
    it.e_q8   = r ? 8'hC3 : it.e_out8;
    if (r) begin
      seen_rst   = 1;
      prev_sel_m = 1'b0;
      toggles_m  = 0;
    end else begin
      if (s != prev_sel_m) toggles_m++;
      prev_sel_m = s;
    end
    it.chk_q   = seen_rst;
    it.chk_cnt = seen_rst;
    it.e_cnt   = (toggles_m > 255) ? 8'hFF : 8'(toggles_m);
    sb.push_back(it);
  endtask

  task automatic check1(input string name, input string what, input logic [7:0] got,
                        input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, what, got, exp);
    end
  endtask

  // Inputs stay put from negedge to negedge, so just after posedge both Out and Out_q are settled.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check1(it.name, "out1", {7'd0, out_1}, {7'd0, it.e_out1});
        check1(it.name, "out8", out_8, it.e_out8);
        if (it.chk_q) begin
          check1(it.name, "out_q1", {7'd0, out_q_1}, {7'd0, it.e_q1});
          check1(it.name, "out_q8", out_q_8, it.e_q8);
        end
`ifdef MUX_SEL_CNT_EN
        if (it.chk_cnt) begin
          check1(it.name, "cnt8", cnt_8, it.e_cnt);
          check1(it.name, "cnt1", cnt_1, it.e_cnt);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    rst = 1'b0; sel = 1'b0; ch0_1 = 1'b0; ch1_1 = 1'b0; ch0_8 = 8'h00; ch1_8 = 8'h00;

    drive("pre_reset", 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    drive("reset0", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hEE);
    drive("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h88);

    drive("vec000", 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02);
    drive("vec100", 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h04);
    drive("vec010", 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h06);
    drive("vec001", 1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 8'h08);
    drive("vec011", 1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h0A);
    drive("vec101", 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 8'h0C);

    drive("load1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
    drive("mid_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
    drive("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 8'h99);

    s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive("alt_a5_3c", 1'b0, s, 1'b0, 1'b1, 8'hA5, 8'h3C);
      s = ~s;
    end

    for (int i = 0; i < 200; i++) begin
      drive("random", ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
    end

    drive("cnt_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      drive("cnt_5", 1'b0, s, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      s = ~s;
      drive("cnt_sat", 1'b0, s, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    drive("cnt_hold", 1'b0, s, 1'b0, 1'b1, 8'h11, 8'h22);
    drive("cnt_clr", 1'b1, s, 1'b0, 1'b1, 8'h11, 8'h22);
    drive("cnt_after", 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
